platform_gen: RTL and testbench
===============================

# platform_gen

Generates and scrolls the three platforms for the game. It owns each platform's vertical and horizontal position and a free-running LFSR that places respawned platforms. It also keeps a landing-independent climb score. It sits directly upstream of the doodle vertical-motion block and the VGA renderer, which read p*_vpos and p*_hpos. It advances once per frame tick, by a scroll amount requested from the game controller.

## Interface
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height; platforms wrap at this line
- PLAT_W, 75, platform width; hpos is kept ≤ H_ACTIVE−PLAT_W (565)
- LFSR_SEED, 10'h2A5, LFSR reset value; must be nonzero
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse; begins or restarts a game
- terminated  in  1  level; game over from the doodle logic
- scroll_amt  in  5  pixels to move platforms down this frame (0–31)
- p1_vpos, p2_vpos, p3_vpos  out  10 each  platform top row
- p1_hpos, p2_hpos, p3_hpos  out  10 each  platform left column
- score  out  16  respawn count, saturating
- running  out  1  high in state RUN

## Operation
- States are IDLE, RUN and OVER. Reset enters IDLE.
- IDLE → RUN on start. RUN → OVER when terminated=1. OVER → RUN on start. OVER never returns to IDLE.
- Entry to RUN from OVER reloads the initial layout and clears score, in the same cycle as the transition.
- Initial layout, also the reset values:
  - p1 = (vpos 80, hpos 100)
  - p2 = (vpos 240, hpos 400)
  - p3 = (vpos 400, hpos 283)
  - score = 0, running = 0
- LFSR: 10-bit Fibonacci, x^10+x^7+1, shifting every clk in all states. It resets to LFSR_SEED and never reaches 0.
- Frame update happens in RUN on frame_tick with terminated=0. For each platform i:
  - n = vpos_i + scroll_amt, computed 11 bits wide.
  - If n ≥ V_ACTIVE: vpos_i ← n − V_ACTIVE (wrap); hpos_i ← place(r_i); respawn_i = 1.
  - Otherwise: vpos_i ← n; hpos_i unchanged.
- Raw placement values, all taken from the current LFSR value L:
  - r1 = L
  - r2 = {L[4:0], L[9:5]}
  - r3 = bit-reverse(L)
- place(r) = r if r < 566, else r − 566. Result range is 0..565.
- score ← score + (number of respawn_i set), saturating at 16'hFFFF.
- Spacing is 160 lines and scroll_amt < 160, so at most one platform wraps per frame. The adder must still accept three.
- Outside RUN, positions and score hold.

## Timing
- All outputs are registered. Positions, score and state update on the clk edge that samples frame_tick or start, and are visible the next cycle.
- Simultaneous events:
  - frame_tick with terminated=1 in RUN: go to OVER, no position update.
  - start with frame_tick in OVER: reload only; scrolling starts on the next tick.
  - start in RUN is ignored.
- rst mid-frame forces the reset values immediately, asynchronously. The LFSR returns to LFSR_SEED.
- scroll_amt = 0: the tick has no effect except that the LFSR keeps running.
- Wrap is exact: vpos 470 + 15 → 5.

## Test plan
- Reset check: assert rst mid-run → immediately p1/p2/p3 vpos = 80/240/400, hpos = 100/400/283, score 0, running 0, state IDLE.
- Idle hold: frame_tick with scroll_amt = 10 while in IDLE → no position change. Then start; next tick → vpos = 90/250/410, running = 1.
- Wrap and place: drive p3 to vpos 470, then tick with scroll_amt = 15 → p3_vpos = 5, p3_hpos = place(bit-reverse(L)) ≤ 565, score +1. Checked against a reference model of the LFSR.
- Placement limit: force L = 10'h3FF through the seed → place = 457, never above 565. Also check 1000 random respawns against the same limit.
- Game over: terminated together with frame_tick → no position update and running = 0. Later ticks → hold. start → initial layout, score 0, RUN.
- Score saturation: preload score 16'hFFFE and force two respawns → score = 16'hFFFF, stays there.

Source files
------------

// File: rtl/platform_if.sv
// platform_if: bundles the frame-rate control inputs and the platform layout
// outputs of platform_gen.
//   frame_tick  one-cycle pulse per video frame
//   start       one-cycle pulse, begins/restarts a game
//   terminated  level, game over from the doodle logic
//   scroll_amt  pixels to move platforms down this frame
//   pN_vpos     platform top row
//   pN_hpos     platform left column
//   score       respawn count, saturating
//   running     high while a game is in progress
// master = game controller side (drives controls), slave = platform_gen.
interface platform_if;
  logic        frame_tick;
  logic        start;
  logic        terminated;
  logic [4:0]  scroll_amt;
  logic [9:0]  p1_vpos;
  logic [9:0]  p2_vpos;
  logic [9:0]  p3_vpos;
  logic [9:0]  p1_hpos;
  logic [9:0]  p2_hpos;
  logic [9:0]  p3_hpos;
  logic [15:0] score;
  logic        running;

  modport master (
    output frame_tick, start, terminated, scroll_amt,
    input  p1_vpos, p2_vpos, p3_vpos, p1_hpos, p2_hpos, p3_hpos, score, running
  );

  modport slave (
    input  frame_tick, start, terminated, scroll_amt,
    output p1_vpos, p2_vpos, p3_vpos, p1_hpos, p2_hpos, p3_hpos, score, running
  );
endinterface

// File: rtl/platform_gen.sv
// platform_gen: owns the three platforms' positions, scrolls them down once per
// frame tick, respawns a platform at the top with an LFSR-derived column when it
// falls past the bottom, and counts respawns as a saturating climb score.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  platform_if.slave (controls in, positions/score/running out)
//
// state | meaning
// IDLE  | after reset, initial layout shown, waiting for start
// RUN   | game in progress, platforms scroll on frame_tick
// OVER  | game ended, layout frozen until start
module platform_gen #(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         PLAT_W    = 75,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input logic       clk,
  input logic       rst,
  platform_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [10:0] V_LIM     = 11'(V_ACTIVE);
  // First column that would push the platform past the right edge.
  localparam logic [9:0]  PLACE_LIM = 10'(H_ACTIVE - PLAT_W + 1);
  // Index 0 is p1, index 2 is p3.
  localparam logic [2:0][9:0] INIT_V = {10'd400, 10'd240, 10'd80};
  localparam logic [2:0][9:0] INIT_H = {10'd283, 10'd400, 10'd100};

  state_t          state_q;
  logic [2:0][9:0] vpos_q;
  logic [2:0][9:0] hpos_q;
  logic [15:0]     score_q;
  logic            running_q;
  logic [9:0]      lfsr_q;

  logic [2:0][9:0] raw;
  logic [2:0][9:0] placed;
  logic [2:0][9:0] vpos_nx;
  logic [2:0][9:0] hpos_nx;
  logic [2:0]      wrap;
  logic [10:0]     n;
  logic [1:0]      n_resp;
  logic [16:0]     score_sum;
  logic [15:0]     score_nx;

  always_comb begin
    raw       = '0;
    placed    = '0;
    vpos_nx   = vpos_q;
    hpos_nx   = hpos_q;
    wrap      = '0;
    n         = '0;
    n_resp    = '0;
    // Three decorrelated column candidates from one LFSR sample.
    raw[0] = lfsr_q;
    raw[1] = {lfsr_q[4:0], lfsr_q[9:5]};
    for (int b = 0; b < 10; b++) raw[2][b] = lfsr_q[9-b];
    for (int i = 0; i < 3; i++) begin
      n       = {1'b0, vpos_q[i]} + {6'd0, bus.scroll_amt};
      wrap[i] = (n >= V_LIM);
      // raw < 1024 < 2*PLACE_LIM, so a single subtraction folds it into range.
      placed[i] = (raw[i] < PLACE_LIM) ? raw[i] : raw[i] - PLACE_LIM;
      if (wrap[i]) begin
        vpos_nx[i] = 10'(n - V_LIM);
        hpos_nx[i] = placed[i];
      end else begin
        vpos_nx[i] = n[9:0];
      end
      n_resp = n_resp + {1'b0, wrap[i]};
    end
    score_sum = {1'b0, score_q} + {15'd0, n_resp};
    score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vpos_q    <= INIT_V;
      hpos_q    <= INIT_H;
      score_q   <= '0;
      running_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      // x^10 + x^7 + 1, free-running in every state.
      lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      case (state_q)
        IDLE, OVER: begin
          if (bus.start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            vpos_q    <= INIT_V;
            hpos_q    <= INIT_H;
            score_q   <= '0;
          end
        end
        RUN: begin
          if (bus.terminated) begin
            state_q   <= OVER;
            running_q <= 1'b0;
          end else if (bus.frame_tick) begin
            vpos_q  <= vpos_nx;
            hpos_q  <= hpos_nx;
            score_q <= score_nx;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p1_vpos = vpos_q[0];
  assign bus.p2_vpos = vpos_q[1];
  assign bus.p3_vpos = vpos_q[2];
  assign bus.p1_hpos = hpos_q[0];
  assign bus.p2_hpos = hpos_q[1];
  assign bus.p3_hpos = hpos_q[2];
  assign bus.score   = score_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_platform_gen.sv
// tb_platform_gen: randomized and directed stimulus for platform_gen, checked by
// a scoreboard fed from a behavioural model of the game rules.
`timescale 1ns/1ps
module tb_platform_gen;

  localparam int         V_ACT = 480;
  localparam int         PLIM  = 566;
  localparam logic [9:0] SEED  = 10'h2A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  platform_if bus();
  platform_gen dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  v0, v1, v2, h0, h1, h2;
    logic [15:0] score;
    logic        run;
  } exp_t;

  exp_t expq[$];

  int mv[3];
  int mh[3];
  int mscore;
  int mstate;          // 0 idle, 1 running, 2 over
  int resp_total = 0;
  logic [9:0] ml = SEED;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] lfsr_next(logic [9:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return 10'(((v * 2) % 1024) + fb);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) ml <= SEED;
    else     ml <= lfsr_next(ml);

  function automatic int place(int r);
    return (r < PLIM) ? r : r - PLIM;
  endfunction

  function automatic int raw_of(int i, int l);
    int r;
    r = 0;
    if (i == 0) r = l;
    else if (i == 1) r = (l % 32) * 32 + (l / 32);
    else for (int k = 0; k < 10; k++) if (((l >> k) & 1) != 0) r += (1 << (9 - k));
    return r;
  endfunction

  task automatic load_init();
    mv[0] = 80;  mv[1] = 240; mv[2] = 400;
    mh[0] = 100; mh[1] = 400; mh[2] = 283;
    mscore = 0;
  endtask

  task automatic model_step(bit tick, bit st, bit term, int s);
    int n;
    if (mstate == 0 || mstate == 2) begin
      if (st) begin load_init(); mstate = 1; end
    end else begin
      if (term) mstate = 2;
      else if (tick) begin
        for (int i = 0; i < 3; i++) begin
          n = mv[i] + s;
          if (n >= V_ACT) begin
            mv[i] = n - V_ACT;
            mh[i] = place(raw_of(i, int'(ml)));
            mscore = (mscore < 65535) ? mscore + 1 : 65535;
            resp_total++;
          end else mv[i] = n;
        end
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_h(int i);
    return (i == 0) ? int'(bus.p1_hpos) : (i == 1) ? int'(bus.p2_hpos) : int'(bus.p3_hpos);
  endfunction

  task automatic check_now(string tag);
    chk({tag, "_p1v"}, int'(bus.p1_vpos), mv[0]);
    chk({tag, "_p2v"}, int'(bus.p2_vpos), mv[1]);
    chk({tag, "_p3v"}, int'(bus.p3_vpos), mv[2]);
    chk({tag, "_p1h"}, int'(bus.p1_hpos), mh[0]);
    chk({tag, "_p2h"}, int'(bus.p2_hpos), mh[1]);
    chk({tag, "_p3h"}, int'(bus.p3_hpos), mh[2]);
    chk({tag, "_score"}, int'(bus.score), mscore);
    chk({tag, "_running"}, int'(bus.running), (mstate == 1) ? 1 : 0);
  endtask

  // Issue one cycle of stimulus; the model's result for the coming edge goes
  // to the scoreboard.
  task automatic drive(bit tick, bit st, bit term, int s);
    exp_t e;
    bus.frame_tick = tick;
    bus.start      = st;
    bus.terminated = term;
    bus.scroll_amt = 5'(s);
    model_step(tick, st, term, s);
    e.cyc = 32'(cyc + 1);
    e.v0 = 10'(mv[0]); e.v1 = 10'(mv[1]); e.v2 = 10'(mv[2]);
    e.h0 = 10'(mh[0]); e.h1 = 10'(mh[1]); e.h2 = 10'(mh[2]);
    e.score = 16'(mscore);
    e.run = (mstate == 1);
    expq.push_back(e);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
  endtask

  // Monitor: compares on the falling edge after the edge each entry targets.
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && int'(expq[0].cyc) < cyc) begin
      e = expq.pop_front();
      failures++;
      $display("FAIL sb_missed: entry for cycle %0d not compared (now %0d)", e.cyc, cyc);
    end
    if (expq.size() > 0 && int'(expq[0].cyc) == cyc) begin
      e = expq.pop_front();
      chk("sb_p1v", int'(bus.p1_vpos), int'(e.v0));
      chk("sb_p2v", int'(bus.p2_vpos), int'(e.v1));
      chk("sb_p3v", int'(bus.p3_vpos), int'(e.v2));
      chk("sb_p1h", int'(bus.p1_hpos), int'(e.h0));
      chk("sb_p2h", int'(bus.p2_hpos), int'(e.h1));
      chk("sb_p3h", int'(bus.p3_hpos), int'(e.h2));
      chk("sb_score", int'(bus.score), int'(e.score));
      chk("sb_running", int'(bus.running), int'(e.run));
      for (int i = 0; i < 3; i++) chk("hpos_in_range", (dut_h(i) <= 565) ? 1 : 0, 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, s, base, k;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.terminated = 1'b0;
    bus.scroll_amt = 5'd0;
    load_init();
    mstate = 0;
    #22 rst = 1'b0;
    @(posedge clk); #1;
    check_now("reset");

    // Ticks in IDLE must not move anything.
    drive(1, 0, 0, 10);
    drive(1, 0, 0, 10);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 10);
    drive(1, 0, 0, 10);
    chk("first_tick_p1v", int'(bus.p1_vpos), 90);
    chk("first_tick_p3v", int'(bus.p3_vpos), 410);

    // Exact wrap: p3 470 + 15 -> 5.
    drive(1, 0, 0, 30);
    drive(1, 0, 0, 30);
    drive(1, 0, 0, 15);
    chk("wrap_p3v", int'(bus.p3_vpos), 5);
    chk("wrap_score", int'(bus.score), 1);
    drive(1, 0, 0, 0);

    // Placement of the all-ones LFSR value.
    idx = 0;
    for (k = 0; k < 60; k++) begin
      idx = 0;
      for (int i = 1; i < 3; i++) if (mv[i] > mv[idx]) idx = i;
      if (mv[idx] >= 465) break;
      s = 479 - mv[idx];
      if (s > 31) s = 31;
      drive(1, 0, 0, s);
    end
    for (k = 0; k < 1100 && ml != 10'h3FF; k++) drive(0, 0, 0, 0);
    if (ml != 10'h3FF) begin
      failures++;
      $display("FAIL wait_lfsr_3ff: value not reached within bound");
    end else begin
      drive(1, 0, 0, 15);
      chk("place_3ff", dut_h(idx), 457);
    end

    // Random scrolling until at least 1000 respawns.
    base = resp_total;
    for (k = 0; k < 15000 && (resp_total - base) < 1000; k++)
      drive(1, ($urandom_range(0, 49) == 0), 0, int'($urandom_range(0, 31)));
    if ((resp_total - base) < 1000) begin
      failures++;
      $display("FAIL random_respawns: got %0d expected at least 1000", resp_total - base);
    end

    // Game over, hold, restart.
    drive(1, 0, 1, 20);
    chk("over_running", int'(bus.running), 0);
    drive(1, 0, 1, 20);
    drive(1, 0, 0, 20);
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 20);
    chk("restart_score", int'(bus.score), 0);
    chk("restart_p2v", int'(bus.p2_vpos), 240);
    drive(1, 0, 0, 10);
    chk("restart_tick_p1v", int'(bus.p1_vpos), 90);

    // Score saturation from a preloaded value.
    @(negedge clk); #1;
    force dut.score_q = 16'hFFFE;
    #1 release dut.score_q;
    mscore = 65534;
    @(posedge clk); #1;
    chk("preload_score", int'(bus.score), 65534);
    base = resp_total;
    for (k = 0; k < 200 && (resp_total - base) < 3; k++) drive(1, 0, 0, 31);
    chk("sat_score", int'(bus.score), 65535);
    for (k = 0; k < 20; k++) drive(1, 0, 0, 31);
    chk("sat_hold", int'(bus.score), 65535);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk); #2;
    rst = 1'b1;
    load_init();
    mstate = 0;
    #1 check_now("midrun_reset");
    #4 rst = 1'b0;
    @(posedge clk); #1;
    drive(1, 0, 0, 10);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 10);

    repeat (3) @(posedge clk);
    #1;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries never compared", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
